// File: rtl/axi_pkg.sv
// Shared encodings and FSM state type for the AXI burst master and its beat address generator.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHK  = 3'd1,
        ST_AW   = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4,
        ST_AR   = 3'd5,
        ST_R    = 3'd6,
        ST_DONE = 3'd7
    } axi_state_e;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Combinational beat address and byte-strobe generator for FIXED/INCR bursts.
module axi_beat_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0]   aligned_addr,
    input  logic [2:0]          size,
    input  logic [1:0]          burst,
    input  logic [7:0]          beat_idx,
    output logic [ADDR_W-1:0]   beat_addr,
    output logic [DATA_W/8-1:0] strb
);

    localparam int NB = DATA_W / 8;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] nbytes;

    always_comb begin
        beat_addr = aligned_addr;
        if (burst == BURST_INCR) begin
            beat_addr = aligned_addr + (ADDR_W'(beat_idx) << size);
        end
        // Lane offset within the data bus; the strobe covers 2^size lanes from there.
        offset = beat_addr & ADDR_W'(NB - 1);
        nbytes = ADDR_W'(1) << size;
        strb   = '0;
        for (int i = 0; i < NB; i++) begin
            strb[i] = (ADDR_W'(i) >= offset) && (ADDR_W'(i) < offset + nbytes);
        end
    end

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI burst master: one command in, one AW/W/B or AR/R burst out, done pulse back.
// Optional 4 KB boundary rejection of INCR bursts is enabled by defining AXI_BURST_4K_CHECK_EN.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_rw,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                done_err,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [2:0]          dbg_state,
    output logic [ADDR_W-1:0]   dbg_beat_addr
);

    localparam int NB = DATA_W / 8;

    // Handshakes on every channel: a transfer happens on the rising edge where valid and
    // ready are both high; ready may precede valid, and a raised valid holds until transfer.

    axi_state_e        state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [7:0]        beat_q, beat_d;
    logic [1:0]        resp_q, resp_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] beat_addr;
    logic [NB-1:0]     beat_strb;
    logic              illegal;
    logic              last_beat;

    assign aligned   = addr_q & ~((ADDR_W'(1) << size_q) - ADDR_W'(1));
    assign last_beat = (beat_q == len_q);

    axi_beat_addr_gen #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_beat_addr_gen (
        .aligned_addr(aligned),
        .size        (size_q),
        .burst       (burst_q),
        .beat_idx    (beat_q),
        .beat_addr   (beat_addr),
        .strb        (beat_strb)
    );

`ifdef AXI_BURST_4K_CHECK_EN
    logic [ADDR_W-1:0] last_byte;
`endif

    always_comb begin
        illegal = 1'b0;
        if (({1'b0, len_q} + 9'd1) > 9'(MAX_LEN)) illegal = 1'b1;
        if ((32'd1 << size_q) > 32'(NB))          illegal = 1'b1;
        if (burst_q > BURST_INCR)                 illegal = 1'b1;
`ifdef AXI_BURST_4K_CHECK_EN
        last_byte = aligned + ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        if ((burst_q == BURST_INCR) && (last_byte[ADDR_W-1:12] != aligned[ADDR_W-1:12])) begin
            illegal = 1'b1;
        end
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            resp_q  <= RESP_OKAY;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        resp_d    = resp_q;
        err_d     = err_q;

        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = rdata;
        done      = 1'b0;
        done_resp = RESP_OKAY;
        done_err  = 1'b0;
        awaddr    = aligned;
        awlen     = len_q;
        awsize    = size_q;
        awburst   = burst_q;
        awvalid   = 1'b0;
        wdata     = wr_data;
        wstrb     = '0;
        wlast     = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        araddr    = aligned;
        arlen     = len_q;
        arsize    = size_q;
        arburst   = burst_q;
        arvalid   = 1'b0;
        rready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    size_d  = cmd_size;
                    burst_d = cmd_burst;
                    beat_d  = '0;
                    resp_d  = RESP_OKAY;
                    err_d   = 1'b0;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    resp_d  = RESP_SLVERR;
                    state_d = ST_DONE;
                end else begin
                    state_d = rw_q ? ST_AR : ST_AW;
                end
            end
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = ST_W;
            end
            ST_W: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = last_beat;
                wstrb    = beat_strb;
                if (wr_valid && wready) begin
                    if (last_beat) state_d = ST_B;
                    else           beat_d  = beat_q + 8'd1;
                end
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    resp_d  = bresp;
                    state_d = ST_DONE;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = ST_R;
            end
            ST_R: begin
                rd_valid = rvalid;
                rready   = rd_ready;
                if (rvalid && rd_ready) begin
                    resp_d = resp_max(resp_q, rresp);
                    // A misplaced or missing rlast is flagged but the burst still runs to cmd_len.
                    if (rlast != last_beat) err_d = 1'b1;
                    if (last_beat) state_d = ST_DONE;
                    else           beat_d  = beat_q + 8'd1;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                done_resp = resp_q;
                done_err  = err_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dbg_state     = state_q;
    assign dbg_beat_addr = beat_addr;

endmodule
